// File: rtl/dec_stage_pipe_if.sv
// Decode-stage bus: instruction handshake, writeback ports and the decoded
// output bundle. The master drives instructions/writebacks, the slave decodes.
interface dec_stage_pipe_if #(
  parameter int DATA_W = 16,
  parameter int BM_W   = 1536
);
  logic [15:0]       inst;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [3:0]        write_reg_addr;
  logic [DATA_W-1:0] write_reg_data;
  logic              write_reg_en;
  logic [1:0]        write_bm_addr;
  logic [BM_W-1:0]   write_bm_data;
  logic              write_bm_en;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       op;
  logic [2:0]        PNZ;
  logic [3:0]        rd_addr;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic [BM_W-1:0]   rbm_data;
  logic [15:0]       se16;
  logic              reg_write;
  logic              halted;

  modport master (
    output inst, in_valid, flush, out_ready,
           write_reg_addr, write_reg_data, write_reg_en,
           write_bm_addr, write_bm_data, write_bm_en,
    input  in_ready, out_valid, op, PNZ, rd_addr, rd_data_1, rd_data_2,
           rbm_data, se16, reg_write, halted
  );

  modport slave (
    input  inst, in_valid, flush, out_ready,
           write_reg_addr, write_reg_data, write_reg_en,
           write_bm_addr, write_bm_data, write_bm_en,
    output in_ready, out_valid, op, PNZ, rd_addr, rd_data_1, rd_data_2,
           rbm_data, se16, reg_write, halted
  );
endinterface

// File: rtl/dec_stage_pipe.sv
// Single-entry decode stage: register/bitmap files with write-through bypass,
// load scoreboards for hazard stalls, HALT latch and a one-bundle output register.
module dec_stage_pipe #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 16,
  parameter int BM_W   = 1536,
  parameter int NBM    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dec_stage_pipe_if.slave bus
);

  localparam logic [3:0] OP_HALT = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_ADD  = 4'd3;
  localparam logic [3:0] OP_BRR  = 4'd4;
  localparam logic [3:0] OP_BR   = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_PLY  = 4'd8;
  localparam logic [3:0] OP_MV   = 4'd9;
  localparam logic [3:0] OP_BSL  = 4'd10;
  localparam logic [3:0] OP_BSH  = 4'd11;
  localparam logic [3:0] OP_SES  = 4'd13;
  localparam logic [3:0] OP_STB  = 4'd14;
  localparam logic [3:0] OP_LDB  = 4'd15;

  // Immediate field width depends on the opcode; everything else carries no immediate.
  function automatic logic [15:0] sext_imm(input logic [15:0] i);
    case (i[15:12])
      OP_BR, OP_BRR:  sext_imm = {{7{i[8]}}, i[8:0]};
      OP_MV, OP_SES:  sext_imm = {{8{i[7]}}, i[7:0]};
      OP_LD, OP_ST:   sext_imm = {{12{i[3]}}, i[3:0]};
      OP_BSL, OP_BSH: sext_imm = {{10{i[5]}}, i[5:0]};
      default:        sext_imm = '0;
    endcase
  endfunction

  logic [DATA_W-1:0] rf_q [NREGS];
  logic [BM_W-1:0]   bm_q [NBM];
  logic [NREGS-1:0]  reg_busy_q, reg_busy_d, reg_clr, reg_set;
  logic [NBM-1:0]    bm_busy_q, bm_busy_d, bm_clr, bm_set;
  logic              halted_q;

  logic              out_valid_q;
  logic [15:0]       op_q, op_d;
  logic [2:0]        pnz_q;
  logic [3:0]        rd_addr_q;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic [BM_W-1:0]   rbm_q, rbm_d;
  logic [15:0]       se16_q;
  logic              rw_q, rw_d;

  logic [3:0]  opc, rd_f, rs1_f, rs2_f;
  logic [1:0]  bma;
  logic        use_rs1, use_rs2, use_bm;
  logic [15:0] reg_eff;
  logic [3:0]  bm_eff;
  logic        hazard, in_ready, accept;

  assign opc   = bus.inst[15:12];
  assign rd_f  = bus.inst[11:8];
  assign rs1_f = bus.inst[7:4];
  assign rs2_f = bus.inst[3:0];
  assign bma   = bus.inst[11:10];

  // Operand usage per opcode.
  always_comb begin
    use_rs1 = opc inside {OP_SUB, OP_ADD, OP_BRR, OP_LD, OP_ST, OP_BSL, OP_BSH};
    use_rs2 = opc inside {OP_SUB, OP_ADD, OP_ST};
    rw_d    = opc inside {OP_SUB, OP_ADD, OP_LD, OP_MV, OP_BSL, OP_BSH};
    use_bm  = opc inside {OP_PLY, OP_STB, OP_LDB};
  end

  // Busy bits released by this cycle's writeback no longer block issue.
  always_comb begin
    reg_clr = '0;
    for (int k = 0; k < NREGS; k++)
      reg_clr[k] = bus.write_reg_en && (bus.write_reg_addr == 4'(k));
    bm_clr = '0;
    for (int k = 0; k < NBM; k++)
      bm_clr[k] = bus.write_bm_en && (bus.write_bm_addr == 2'(k));
    reg_eff = 16'(reg_busy_q & ~reg_clr);
    bm_eff  = 4'(bm_busy_q & ~bm_clr);
  end

  assign hazard = (use_rs1 && reg_eff[rs1_f]) || (use_rs2 && reg_eff[rs2_f]) ||
                  (rw_d && reg_eff[rd_f]) || (use_bm && bm_eff[bma]);
  assign in_ready = rst_n && !halted_q && !bus.flush && !hazard &&
                    (!out_valid_q || bus.out_ready);
  assign accept = bus.in_valid && in_ready;

  // Operand reads with write-through bypass from the writeback ports.
  always_comb begin
    rd1_d = '0;
    rd2_d = '0;
    if (int'(rs1_f) < NREGS) rd1_d = rf_q[rs1_f];
    if (int'(rs2_f) < NREGS) rd2_d = rf_q[rs2_f];
    if (bus.write_reg_en && bus.write_reg_addr == rs1_f) rd1_d = bus.write_reg_data;
    if (bus.write_reg_en && bus.write_reg_addr == rs2_f) rd2_d = bus.write_reg_data;
    rbm_d = '0;
    if (int'(bma) < NBM) rbm_d = bm_q[bma];
    if (bus.write_bm_en && bus.write_bm_addr == bma) rbm_d = bus.write_bm_data;
    op_d = 16'(1) << opc;
  end

  // Scoreboard next state: flush clears everything, otherwise a new LD/LDB set beats a release.
  always_comb begin
    reg_set = '0;
    bm_set  = '0;
    if (accept && opc == OP_LD && int'(rd_f) < NREGS) reg_set[rd_f] = 1'b1;
    if (accept && opc == OP_LDB && int'(bma) < NBM)   bm_set[bma]   = 1'b1;
    reg_busy_d = bus.flush ? '0 : ((reg_busy_q & ~reg_clr) | reg_set);
    bm_busy_d  = bus.flush ? '0 : ((bm_busy_q & ~bm_clr) | bm_set);
  end

  // Scoreboards and HALT latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_busy_q <= '0;
      bm_busy_q  <= '0;
      halted_q   <= 1'b0;
    end else begin
      reg_busy_q <= reg_busy_d;
      bm_busy_q  <= bm_busy_d;
      if (bus.flush)                     halted_q <= 1'b0;
      else if (accept && opc == OP_HALT) halted_q <= 1'b1;
    end
  end

  // Register and bitmap files; writeback continues through flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NREGS; k++) rf_q[k] <= '0;
      for (int k = 0; k < NBM; k++)   bm_q[k] <= '0;
    end else begin
      if (bus.write_reg_en && int'(bus.write_reg_addr) < NREGS)
        rf_q[bus.write_reg_addr] <= bus.write_reg_data;
      if (bus.write_bm_en && int'(bus.write_bm_addr) < NBM)
        bm_q[bus.write_bm_addr] <= bus.write_bm_data;
    end
  end

  // Output bundle register: load on accept, drain on handshake, hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      pnz_q       <= '0;
      rd_addr_q   <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rbm_q       <= '0;
      se16_q      <= '0;
      rw_q        <= 1'b0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op_q        <= op_d;
      pnz_q       <= bus.inst[11:9];
      rd_addr_q   <= rd_f;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      rbm_q       <= rbm_d;
      se16_q      <= sext_imm(bus.inst);
      rw_q        <= rw_d;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.op        = op_q;
  assign bus.PNZ       = pnz_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.rd_data_1 = rd1_q;
  assign bus.rd_data_2 = rd2_q;
  assign bus.rbm_data  = rbm_q;
  assign bus.se16      = se16_q;
  assign bus.reg_write = rw_q;
  assign bus.halted    = halted_q;

endmodule

// File: tb/tb_dec_stage_pipe.sv
// Directed bench for dec_stage_pipe with an expected-bundle queue.
module tb_dec_stage_pipe;
  localparam int DATA_W = 16;
  localparam int BM_W   = 1536;

  typedef struct {
    logic [15:0]     op;
    logic [2:0]      pnz;
    logic [3:0]      rd;
    logic [15:0]     d1;
    logic [15:0]     d2;
    logic [BM_W-1:0] bm;
    logic [15:0]     se;
    logic            rw;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dec_stage_pipe_if #(.DATA_W(DATA_W), .BM_W(BM_W)) bus ();

  dec_stage_pipe #(.DATA_W(DATA_W), .NREGS(16), .BM_W(BM_W), .NBM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int ncmp = 0;
  int nfail = 0;
  bundle_t q[$];
  logic [15:0]     mrf [16];
  logic [BM_W-1:0] mbm [4];
  logic            p_wre, p_wbe;
  logic [3:0]      p_wra;
  logic [15:0]     p_wrd;
  logic [1:0]      p_wba;
  logic [BM_W-1:0] p_wbd;
  logic [BM_W-1:0] pat1, pat2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bm(input string tag, input logic [BM_W-1:0] obs, input logic [BM_W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got ..%h expected ..%h (low 64 bits)", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic bundle_t model(input logic [15:0] i);
    bundle_t b;
    b.op  = 16'd1 << i[15:12];
    b.pnz = i[11:9];
    b.rd  = i[11:8];
    b.d1  = mrf[i[7:4]];
    b.d2  = mrf[i[3:0]];
    b.bm  = mbm[i[11:10]];
    case (i[15:12])
      4'd4, 4'd5:   b.se = 16'($signed(i[8:0]));
      4'd9, 4'd13:  b.se = 16'($signed(i[7:0]));
      4'd6, 4'd7:   b.se = 16'($signed(i[3:0]));
      4'd10, 4'd11: b.se = 16'($signed(i[5:0]));
      default:      b.se = 16'h0000;
    endcase
    b.rw = (i[15:12] == 4'd2) || (i[15:12] == 4'd3) || (i[15:12] == 4'd6) ||
           (i[15:12] == 4'd9) || (i[15:12] == 4'd10) || (i[15:12] == 4'd11);
    return b;
  endfunction

  task automatic chk_bundle(input bundle_t b);
    chk("op",        64'(bus.op),        64'(b.op));
    chk("PNZ",       64'(bus.PNZ),       64'(b.pnz));
    chk("rd_addr",   64'(bus.rd_addr),   64'(b.rd));
    chk("rd_data_1", 64'(bus.rd_data_1), 64'(b.d1));
    chk("rd_data_2", 64'(bus.rd_data_2), 64'(b.d2));
    chk_bm("rbm_data", bus.rbm_data, b.bm);
    chk("se16",      64'(bus.se16),      64'(b.se));
    chk("reg_write", 64'(bus.reg_write), 64'(b.rw));
  endtask

  // One clock: drive, check pre-edge, update the expected queue, advance to edge+1.
  task automatic step(input logic [15:0] i, input logic v, input logic ordy,
                      input logic fl, input logic exp_rdy);
    bus.inst = i; bus.in_valid = v; bus.out_ready = ordy; bus.flush = fl;
    bus.write_reg_en = p_wre; bus.write_reg_addr = p_wra; bus.write_reg_data = p_wrd;
    bus.write_bm_en = p_wbe; bus.write_bm_addr = p_wba; bus.write_bm_data = p_wbd;
    #3;
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk_bundle(q[0]);
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    if (q.size() != 0 && ordy) void'(q.pop_front());
    if (p_wre) mrf[p_wra] = p_wrd;
    if (p_wbe) mbm[p_wba] = p_wbd;
    if (fl) q.delete();
    if (v && exp_rdy && !fl) q.push_back(model(i));
    @(posedge clk); #1;
    p_wre = 1'b0; p_wbe = 1'b0;
  endtask

  initial begin
    pat1 = {48{32'hA5C3_0001}};
    pat2 = {48{32'h1234_8765}};
    for (int k = 0; k < 16; k++) mrf[k] = '0;
    for (int k = 0; k < 4; k++)  mbm[k] = '0;
    p_wre = 0; p_wra = 0; p_wrd = 0; p_wbe = 0; p_wba = 0; p_wbd = '0;
    bus.inst = 16'h3312; bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b0;
    bus.write_reg_en = 0; bus.write_reg_addr = 0; bus.write_reg_data = 0;
    bus.write_bm_en = 0; bus.write_bm_addr = 0; bus.write_bm_data = '0;

    // Reset with a valid instruction pending
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_halted",    64'(bus.halted),    64'd0);
    chk("rst_op",        64'(bus.op),        64'd0);
    chk("rst_rd_data_1", 64'(bus.rd_data_1), 64'd0);
    chk("rst_se16",      64'(bus.se16),      64'd0);
    chk("rst_reg_write", 64'(bus.reg_write), 64'd0);
    chk_bm("rst_rbm", bus.rbm_data, '0);
    rst_n = 1'b1;

    // Preload r1=5, r2=7, bm1
    p_wre = 1; p_wra = 4'd1; p_wrd = 16'd5; step(16'h0000, 0, 1, 0, 1);
    p_wre = 1; p_wra = 4'd2; p_wrd = 16'd7; step(16'h0000, 0, 1, 0, 1);
    p_wbe = 1; p_wba = 2'd1; p_wbd = pat1;  step(16'h0000, 0, 1, 0, 1);

    // ADD r3,r1,r2
    step(16'h3312, 1, 1, 0, 1);
    chk("add_valid", 64'(bus.out_valid), 64'd1);
    chk("add_op3",   64'(bus.op),        64'h0008);
    chk("add_rs1",   64'(bus.rd_data_1), 64'd5);
    chk("add_rs2",   64'(bus.rd_data_2), 64'd7);
    chk("add_rw",    64'(bus.reg_write), 64'd1);

    // ADD r6,r7,r1 with r7 written the same cycle (bypass)
    p_wre = 1; p_wra = 4'd7; p_wrd = 16'h1234; step(16'h3671, 1, 1, 0, 1);
    chk("bypass_rs1", 64'(bus.rd_data_1), 64'h1234);

    // Back-to-back: SUB, MV, BR, PLY, BSL, ST
    step(16'h2312, 1, 1, 0, 1);
    step(16'h957F, 1, 1, 0, 1);
    chk("mv_se16", 64'(bus.se16), 64'h007F);
    step(16'h5BF0, 1, 1, 0, 1);
    chk("br_se16", 64'(bus.se16), 64'hFFF0);
    chk("br_pnz",  64'(bus.PNZ),  64'd5);
    step(16'h8400, 1, 1, 0, 1);
    step(16'hA13E, 1, 1, 0, 1);
    step(16'h7128, 1, 1, 0, 1);
    step(16'h0000, 0, 1, 0, 1);

    // LD r4 then dependent ADD r5,r4,r0 released by writeback
    step(16'h6400, 1, 1, 0, 1);
    step(16'h3540, 1, 1, 0, 0);
    step(16'h3540, 1, 1, 0, 0);
    p_wre = 1; p_wra = 4'd4; p_wrd = 16'h0009; step(16'h3540, 1, 1, 0, 1);
    chk("ld_release_rs1", 64'(bus.rd_data_1), 64'h0009);
    step(16'h0000, 0, 1, 0, 1);

    // Backpressure: bundle held 3 cycles, then next instruction same cycle
    step(16'h3312, 1, 1, 0, 1);
    step(16'h2312, 1, 0, 0, 0);
    step(16'h2312, 1, 0, 0, 0);
    step(16'h2312, 1, 0, 0, 0);
    step(16'h2312, 1, 1, 0, 1);
    step(16'h0000, 0, 1, 0, 1);

    // LDB bm2 then STB bm2 waits for bitmap writeback
    step(16'hF800, 1, 1, 0, 1);
    step(16'hE800, 1, 1, 0, 0);
    p_wbe = 1; p_wba = 2'd2; p_wbd = pat2; step(16'hE800, 1, 1, 0, 1);
    step(16'h0000, 0, 1, 0, 1);

    // LD r2 colliding with a writeback to r2: busy bit stays set
    p_wre = 1; p_wra = 4'd2; p_wrd = 16'h00AA; step(16'h6200, 1, 1, 0, 1);
    step(16'h3520, 1, 1, 0, 0);
    step(16'h3520, 1, 1, 0, 0);
    step(16'h3520, 1, 1, 1, 0);
    step(16'h3520, 1, 1, 0, 1);
    step(16'h0000, 0, 1, 0, 1);

    // LD r9, LDB bm3, HALT; stall 10 cycles; flush clears halt and scoreboards
    step(16'h6900, 1, 1, 0, 1);
    step(16'hFC00, 1, 1, 0, 1);
    step(16'h1000, 1, 1, 0, 1);
    chk("halted_set", 64'(bus.halted), 64'd1);
    for (int k = 0; k < 10; k++) step(16'h0000, 1, 1, 0, 0);
    chk("halted_hold", 64'(bus.halted), 64'd1);
    step(16'h3A90, 1, 1, 1, 0);
    chk("flush_halted", 64'(bus.halted),    64'd0);
    chk("flush_valid",  64'(bus.out_valid), 64'd0);
    step(16'h3A90, 1, 1, 0, 1);
    step(16'hEC00, 1, 1, 0, 1);
    step(16'h0000, 0, 1, 0, 1);

    // Reset while a bundle is held under backpressure
    step(16'h3312, 1, 1, 0, 1);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("midrst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_op",    64'(bus.op),        64'd0);
    q.delete();
    for (int k = 0; k < 16; k++) mrf[k] = '0;
    for (int k = 0; k < 4; k++)  mbm[k] = '0;
    rst_n = 1'b1;
    step(16'h3312, 1, 1, 0, 1);
    step(16'h8400, 1, 1, 0, 1);
    step(16'h0000, 0, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
